// File: rtl/seq_arb_rr_lock_pkg.sv
// seq_arb_rr_lock_pkg: shared constants and helpers for the
// round-robin lock arbiter (PRIO_MODE encodings, onehot->index).
package seq_arb_rr_lock_pkg;

  localparam int PRIO_ROTATE = 0;
  localparam int PRIO_RR     = 1;

  localparam int OH_MAXW = 64;

  // OR of the indices of all set bits; exact for one-hot or zero.
  function automatic int unsigned oh2idx(
    input logic [OH_MAXW-1:0] oh
  );
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < OH_MAXW; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_arb_rr_lock_if.sv
// seq_arb_rr_lock_if: request/lock in, grant out.
// master drives reqs/lock; slave (the arbiter) drives grants.
interface seq_arb_rr_lock_if #(
  parameter int NREQS = 4
);
  localparam int IW = (NREQS > 1) ? $clog2(NREQS) : 1;

  logic [NREQS-1:0] reqs;
  logic             lock;
  logic [NREQS-1:0] grants;
  logic             grant_val;
  logic [IW-1:0]    grant_idx;

  modport master (
    output reqs, lock,
    input  grants, grant_val, grant_idx
  );

  modport slave (
    input  reqs, lock,
    output grants, grant_val, grant_idx
  );
endinterface

// File: rtl/seq_arb_rr_lock_arb_rr_comb.sv
// arb_rr_comb: combinational variable-priority scan.
// Ports: reqs, prio (one-hot start point) -> grants (one-hot or 0).
module arb_rr_comb #(
  parameter int NREQS = 4
) (
  input  logic [NREQS-1:0] reqs,
  input  logic [NREQS-1:0] prio,
  output logic [NREQS-1:0] grants
);

  logic [2*NREQS-1:0] dreq;
  logic [2*NREQS-1:0] dgnt;

  // Subtracting prio from the doubled request vector clears the
  // lowest set bit at or above prio; the and-not keeps just it.
  always_comb begin
    dreq   = {reqs, reqs};
    dgnt   = dreq & ~(dreq - {{NREQS{1'b0}}, prio});
    grants = dgnt[NREQS-1:0] | dgnt[2*NREQS-1:NREQS];
  end

endmodule

// File: rtl/seq_arb_rr_lock.sv
// seq_arb_rr_lock: N-way round-robin arbiter with grant lock.
// Ports: clk, reset_n (async low), bus (slave: reqs/lock/grants).
module seq_arb_rr_lock
  import seq_arb_rr_lock_pkg::*;
#(
  parameter int NREQS     = 4,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MAX_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_arb_rr_lock_if.slave  bus
);

  localparam int IW = $clog2(NREQS);
  localparam int HW =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [NREQS-1:0] PRIO_RST =
    {{(NREQS-1){1'b0}}, 1'b1};

  logic [NREQS-1:0] prio, prio_nxt;
  logic             held_vld, held_vld_nxt;
  logic [IW-1:0]    held_idx, held_idx_nxt;
  logic [HW-1:0]    hold_cnt, hold_cnt_nxt;

  logic [NREQS-1:0] scan_gnt;
  logic [NREQS-1:0] held_oh;
  logic [NREQS-1:0] gnt;
  logic             gval;
  logic [IW-1:0]    gidx;
  logic             under_cap;
  logic             held_active;
  logic [HW-1:0]    cnt_inc;

  arb_rr_comb #(
    .NREQS (NREQS)
  ) u_scan (
    .reqs   (bus.reqs),
    .prio   (prio),
    .grants (scan_gnt)
  );

  always_comb begin
    under_cap   = (MAX_HOLD == 0) ||
                  (int'(hold_cnt) < MAX_HOLD);
    held_active = held_vld & bus.reqs[held_idx] &
                  bus.lock & under_cap;
    held_oh     = PRIO_RST << held_idx;
    gnt         = '0;
    // Outputs are forced quiet while reset is asserted.
    if (reset_n) gnt = held_active ? held_oh : scan_gnt;
    gval        = |gnt;
    gidx        = IW'(oh2idx(OH_MAXW'(gnt)));
  end

  assign bus.grants    = gnt;
  assign bus.grant_val = gval;
  assign bus.grant_idx = gidx;

  always_comb begin
    cnt_inc = (hold_cnt == {HW{1'b1}}) ?
              hold_cnt : hold_cnt + HW'(1);
  end

  always_comb begin
    prio_nxt     = prio;
    held_vld_nxt = 1'b0;
    held_idx_nxt = held_idx;
    hold_cnt_nxt = '0;
    if (PRIO_MODE == PRIO_ROTATE) begin
      prio_nxt = {prio[NREQS-2:0], prio[NREQS-1]};
    end else if (gval) begin
      // Next scan starts one past the winner.
      prio_nxt = {gnt[NREQS-2:0], gnt[NREQS-1]};
    end
    if (gval && bus.lock) begin
      held_vld_nxt = 1'b1;
      held_idx_nxt = gidx;
      hold_cnt_nxt = held_active ? cnt_inc : HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio     <= PRIO_RST;
      held_vld <= 1'b0;
      held_idx <= '0;
      hold_cnt <= '0;
    end else begin
      prio     <= prio_nxt;
      held_vld <= held_vld_nxt;
      held_idx <= held_idx_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seq_arb_rr_lock.sv
// tb_seq_arb_rr_lock: three configurations against an index-level
// model, directed literal sequences plus randomized traffic.
module tb_seq_arb_rr_lock;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] r4 = '0;
  logic       l4 = 1'b0;
  logic [7:0] r8 = '0;
  logic       l8 = 1'b0;

  always #5 clk = ~clk;

  seq_arb_rr_lock_if #(.NREQS(4)) ifa ();
  seq_arb_rr_lock_if #(.NREQS(4)) ifb ();
  seq_arb_rr_lock_if #(.NREQS(8)) ifc ();

  assign ifa.reqs = r4;
  assign ifa.lock = l4;
  assign ifb.reqs = r4;
  assign ifb.lock = l4;
  assign ifc.reqs = r8;
  assign ifc.lock = l8;

  seq_arb_rr_lock #(
    .NREQS(4), .PRIO_MODE(1), .MAX_HOLD(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );

  seq_arb_rr_lock #(
    .NREQS(4), .PRIO_MODE(0), .MAX_HOLD(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  seq_arb_rr_lock #(
    .NREQS(8), .PRIO_MODE(1), .MAX_HOLD(0)
  ) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  // Model state: next-scan start index, holder, hold length.
  int ptr [3];
  bit hv  [3];
  int hi  [3];
  int hc  [3];

  function automatic int nr(int d);
    return (d == 2) ? 8 : 4;
  endfunction

  function automatic int pm(int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic int mh(int d);
    return (d == 2) ? 0 : 4;
  endfunction

  function automatic logic [7:0] rq(int d);
    return (d == 2) ? r8 : {4'b0, r4};
  endfunction

  function automatic bit lk(int d);
    return (d == 2) ? l8 : l4;
  endfunction

  function automatic bit act(int d);
    logic [7:0] r;
    r = rq(d);
    return hv[d] && r[hi[d]] && lk(d) &&
           (mh(d) == 0 || hc[d] < mh(d));
  endfunction

  function automatic int exp_idx(int d);
    logic [7:0] r;
    r = rq(d);
    if (act(d)) return hi[d];
    for (int k = 0; k < nr(d); k++) begin
      if (r[(ptr[d] + k) % nr(d)]) return (ptr[d] + k) % nr(d);
    end
    return -1;
  endfunction

  function automatic logic [11:0] dut_word(int d);
    if (d == 0)
      return {4'b0, ifa.grants, ifa.grant_val,
              1'b0, ifa.grant_idx};
    if (d == 1)
      return {4'b0, ifb.grants, ifb.grant_val,
              1'b0, ifb.grant_idx};
    return {ifc.grants, ifc.grant_val, ifc.grant_idx};
  endfunction

  task automatic chk(input string nm,
                     input logic [11:0] got,
                     input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t",
               nm, got, want, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 3; d++) begin
        ptr[d] = 0; hv[d] = 0; hi[d] = 0; hc[d] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        int g;
        bit a;
        g = exp_idx(d);
        a = act(d);
        if (pm(d) == 0) ptr[d] = (ptr[d] + 1) % nr(d);
        else if (g >= 0) ptr[d] = (g + 1) % nr(d);
        if (g >= 0 && lk(d)) begin
          hc[d] = a ? hc[d] + 1 : 1;
          hv[d] = 1;
          hi[d] = g;
        end else begin
          hv[d] = 0;
          hc[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int g;
      logic [11:0] e;
      e = '0;
      if (reset_n) begin
        g = exp_idx(d);
        if (g >= 0) e = {8'(1) << g, 1'b1, 3'(g)};
      end
      chk($sformatf("model_dut%0d", d), dut_word(d), e);
    end
  end

  task automatic rst();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    r4 = '0; l4 = 1'b0; r8 = '0; l8 = 1'b0;
  endtask

  // Drive after a rising edge; return 4 time units later.
  task automatic drive(input logic [3:0] a, input logic la,
                       input logic [7:0] c, input logic lc);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    r4 = a; l4 = la; r8 = c; l8 = lc;
    #3;
  endtask

  logic [3:0] seq_a [];
  logic [3:0] seq_b [];

  initial begin
    rst();
    seq_a = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    foreach (seq_a[i]) begin
      drive(4'hf, 1'b0, 8'h0, 1'b0);
      chk("rr_all_a", {8'h0, ifa.grants}, {8'h0, seq_a[i]});
    end

    rst();
    seq_a = '{4'h1, 4'h4, 4'h1, 4'h4};
    seq_b = '{4'h1, 4'h4, 4'h4, 4'h1};
    foreach (seq_a[i]) begin
      drive(4'h5, 1'b0, 8'h0, 1'b0);
      chk("rr_0101_a", {8'h0, ifa.grants}, {8'h0, seq_a[i]});
      chk("rot_0101_b", {8'h0, ifb.grants}, {8'h0, seq_b[i]});
    end

    rst();
    for (int i = 0; i < 12; i++) begin
      logic [3:0] eg;
      eg = 4'h1 << (i / 4);
      drive(4'hf, 1'b1, 8'h0, 1'b0);
      chk("max_hold_a", {6'h0, ifa.grants, ifa.grant_idx},
          {6'h0, eg, 2'(i / 4)});
    end

    rst();
    drive(4'h3, 1'b1, 8'h0, 1'b0);
    chk("early_rel0", {8'h0, ifa.grants}, 12'h1);
    drive(4'h3, 1'b1, 8'h0, 1'b0);
    chk("early_rel1", {8'h0, ifa.grants}, 12'h1);
    drive(4'h3, 1'b0, 8'h0, 1'b0);
    chk("early_rel2", {8'h0, ifa.grants}, 12'h2);

    rst();
    drive(4'h4, 1'b1, 8'h0, 1'b0);
    chk("drop_hold", {8'h0, ifa.grants}, 12'h4);
    drive(4'hb, 1'b1, 8'h0, 1'b0);
    chk("drop_move", {8'h0, ifa.grants}, 12'h8);
    drive(4'hb, 1'b1, 8'h0, 1'b0);
    chk("drop_newhold", {8'h0, ifa.grants}, 12'h8);

    rst();
    drive(4'h4, 1'b1, 8'h0, 1'b0);
    drive(4'h4, 1'b1, 8'h0, 1'b0);
    chk("pre_rst_hold", {8'h0, ifa.grants}, 12'h4);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_hold", dut_word(0), 12'h0);
    drive(4'hf, 1'b0, 8'h0, 1'b0);
    chk("post_rst", {8'h0, ifa.grants}, 12'h1);

    rst();
    for (int i = 0; i < 10; i++) begin
      drive(4'h0, 1'b0, 8'h81, 1'b1);
      chk("unl_hold_c", {4'h0, ifc.grants}, 12'h01);
    end
    drive(4'h0, 1'b0, 8'h81, 1'b0);
    chk("unl_rel_c", {4'h0, ifc.grants}, 12'h80);

    rst();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst();
      end else begin
        drive(4'($urandom), $urandom_range(0, 3) != 0,
              8'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    @(posedge clk);
    #6;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
